// File: rtl/render_scheduler.sv
// Frame-level triangle scheduler: clears buffers, then walks triangles through fetch/raster.
// Optional rasterizer watchdog enabled by defining RENDER_SCHED_TIMEOUT_EN.
module render_scheduler #(
    parameter int TRI_ADDR_WIDTH = 8,
    parameter int RASTER_TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [TRI_ADDR_WIDTH-1:0] tri_count,
    output logic                      clear_req,
    input  logic                      fb_ready,
    input  logic                      db_ready,
    output logic [TRI_ADDR_WIDTH-1:0] tri_addr,
    output logic                      tri_fetch,
    output logic                      raster_start,
    input  logic                      raster_done,
    output logic                      busy,
    output logic                      frame_done,
    output logic [TRI_ADDR_WIDTH-1:0] tri_drawn,
    output logic                      timeout_err
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        CLEAR       = 4'd1,
        WAIT_CLEAR  = 4'd2,
        FETCH       = 4'd3,
        LOAD        = 4'd4,
        START       = 4'd5,
        WAIT_RASTER = 4'd6,
        NEXT        = 4'd7,
        DONE        = 4'd8
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [TRI_ADDR_WIDTH-1:0] count_r;
    logic [TRI_ADDR_WIDTH-1:0] count_s;
    logic [TRI_ADDR_WIDTH-1:0] addr_s;
    logic [TRI_ADDR_WIDTH-1:0] drawn_s;
    logic                      wait_armed_r;
    logic                      last_s;
    logic                      timeout_hit_s;

    assign last_s = (tri_addr == (count_r - TRI_ADDR_WIDTH'(1)));

`ifdef RENDER_SCHED_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(RASTER_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(RASTER_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    assign timeout_hit_s = (state_r == WAIT_RASTER) && (tmo_cnt_r == TMO_LAST);

    // Watchdog: counts cycles spent in WAIT_RASTER, restarting on every entry
    always_ff @(posedge clk) begin
        if (rst || (state_r != WAIT_RASTER)) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Sticky error flag, only cleared by reset or a newly accepted frame
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if ((state_r == IDLE) && frame_start) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit_s && !raster_done) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (RASTER_TIMEOUT > 0);
    assign timeout_hit_s      = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // Next-state and next-datapath decode
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        addr_s  = tri_addr;
        drawn_s = tri_drawn;
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_s = CLEAR;
                    count_s = tri_count;
                    addr_s  = '0;
                    drawn_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR:      state_s = WAIT_CLEAR;
            // First WAIT_CLEAR cycle is skipped so stale ready levels cannot short-circuit the clear
            WAIT_CLEAR: begin
                if (wait_armed_r && fb_ready && db_ready) begin
                    state_s = (count_r == '0) ? DONE : FETCH;
                end else begin
                    state_s = WAIT_CLEAR;
                end
            end
            FETCH:      state_s = LOAD;
            LOAD:       state_s = START;
            START:      state_s = WAIT_RASTER;
            WAIT_RASTER: begin
                if (raster_done || timeout_hit_s) begin
                    state_s = NEXT;
                end else begin
                    state_s = WAIT_RASTER;
                end
            end
            NEXT: begin
                drawn_s = tri_drawn + TRI_ADDR_WIDTH'(1);
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    addr_s  = tri_addr + TRI_ADDR_WIDTH'(1);
                    state_s = FETCH;
                end
            end
            DONE:       state_s = IDLE;
            default:    state_s = IDLE;
        endcase
    end

    // State, datapath and registered output strobes decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            count_r      <= '0;
            tri_addr     <= '0;
            tri_drawn    <= '0;
            wait_armed_r <= 1'b0;
            busy         <= 1'b0;
            clear_req    <= 1'b0;
            tri_fetch    <= 1'b0;
            raster_start <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            tri_addr     <= addr_s;
            tri_drawn    <= drawn_s;
            wait_armed_r <= (state_r == WAIT_CLEAR);
            busy         <= (state_s != IDLE);
            clear_req    <= (state_s == CLEAR);
            tri_fetch    <= (state_s == FETCH);
            raster_start <= (state_s == START);
            frame_done   <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler; a scoreboard holds expected fetch addresses and frame triangle totals.
module tb_render_scheduler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic [W-1:0] tri_count;
    logic         clear_req;
    logic         fb_ready;
    logic         db_ready;
    logic [W-1:0] tri_addr;
    logic         tri_fetch;
    logic         raster_start;
    logic         raster_done;
    logic         busy;
    logic         frame_done;
    logic [W-1:0] tri_drawn;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int n_clear = 0;
    int n_fetch = 0;
    int n_start = 0;
    int n_done  = 0;

    logic [W-1:0] addr_q[$];
    logic [W-1:0] drawn_q[$];
    logic [3:0]   strobe_prev = 4'b0000;

    render_scheduler #(.TRI_ADDR_WIDTH(W), .RASTER_TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .tri_count(tri_count),
        .clear_req(clear_req), .fb_ready(fb_ready), .db_ready(db_ready),
        .tri_addr(tri_addr), .tri_fetch(tri_fetch), .raster_start(raster_start),
        .raster_done(raster_done), .busy(busy), .frame_done(frame_done),
        .tri_drawn(tri_drawn), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Monitor: strobe widths, pulse counts, and scoreboard pops on fetch / frame completion
    always @(negedge clk) begin
        logic [3:0]   strobes;
        logic [W-1:0] e;
        if (rst) begin
            strobe_prev = 4'b0000;
        end else begin
            strobes = {clear_req, tri_fetch, raster_start, frame_done};
            if (|strobes) begin
                checks++;
                assert ((strobes & strobe_prev) === 4'b0000) else begin
                    errors++;
                    $error("FAIL strobe_width: observed %b after %b, expected single-cycle", strobes, strobe_prev);
                end
            end
            strobe_prev = strobes;
            if (clear_req)    n_clear++;
            if (raster_start) n_start++;
            if (tri_fetch) begin
                n_fetch++;
                checks++;
                assert (addr_q.size() > 0) else begin
                    errors++;
                    $error("FAIL fetch_unexpected: observed fetch of %0d, expected none", tri_addr);
                end
                if (addr_q.size() > 0) begin
                    e = addr_q.pop_front();
                    checks++;
                    assert (tri_addr === e) else begin
                        errors++;
                        $error("FAIL tri_addr: observed %0d, expected %0d", tri_addr, e);
                    end
                end
            end
            if (frame_done) begin
                n_done++;
                checks++;
                assert (drawn_q.size() > 0) else begin
                    errors++;
                    $error("FAIL frame_unexpected: observed frame_done, expected none");
                end
                if (drawn_q.size() > 0) begin
                    e = drawn_q.pop_front();
                    checks++;
                    assert (tri_drawn === e) else begin
                        errors++;
                        $error("FAIL tri_drawn: observed %0d, expected %0d", tri_drawn, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return clear_req;
            1:       return tri_fetch;
            2:       return raster_start;
            3:       return frame_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_high(input int which, input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sig(which)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        assert (seen === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed timeout after %0d cycles, expected strobe", tag, budget);
        end
    endtask

    task automatic start_frame(input int cnt);
        tri_count   = W'(cnt);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic serve_tri(input int delay);
        wait_high(2, "raster_start_wait", 200);
        repeat (delay) @(negedge clk);
        raster_done = 1'b1;
        @(negedge clk);
        raster_done = 1'b0;
    endtask

    initial begin
        int c0, f0, s0, d0, k;
        rst = 1'b1; frame_start = 1'b0; tri_count = '0;
        fb_ready = 1'b0; db_ready = 1'b0; raster_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_strobes", {busy, clear_req, tri_fetch, raster_start, frame_done, timeout_err}, 0);
        chk("reset_addr", tri_addr, 0);
        chk("reset_drawn", tri_drawn, 0);

        // Three triangles, readies 5 cycles after clear, raster 10 cycles per triangle
        c0 = n_clear; f0 = n_fetch; s0 = n_start; d0 = n_done;
        addr_q.push_back(8'd0); addr_q.push_back(8'd1); addr_q.push_back(8'd2);
        drawn_q.push_back(8'd3);
        start_frame(3);
        chk("clear_req_n1", clear_req, 1);
        repeat (5) @(negedge clk);
        fb_ready = 1'b1; db_ready = 1'b1;
        for (int t = 0; t < 3; t++) serve_tri(10);
        wait_high(3, "frame_done_3", 100);
        @(negedge clk);
        chk("f3_clears", n_clear - c0, 1);
        chk("f3_fetches", n_fetch - f0, 3);
        chk("f3_starts", n_start - s0, 3);
        chk("f3_dones", n_done - d0, 1);
        chk("f3_idle", busy, 0);
        chk("f3_drawn_hold", tri_drawn, 3);

        // Zero triangles with readies held high: WAIT_CLEAR is exactly two cycles
        c0 = n_clear; f0 = n_fetch; s0 = n_start;
        drawn_q.push_back(8'd0);
        start_frame(0);
        k = 0;
        while (!frame_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("f0_clear_to_done", k, 3);
        @(negedge clk);
        chk("f0_clears", n_clear - c0, 1);
        chk("f0_fetches", n_fetch - f0, 0);
        chk("f0_starts", n_start - s0, 0);

        // fb_ready alone must not release WAIT_CLEAR; stray frame_start/raster_done ignored
        c0 = n_clear; f0 = n_fetch; d0 = n_done;
        db_ready = 1'b0;
        addr_q.push_back(8'd0);
        drawn_q.push_back(8'd1);
        start_frame(1);
        repeat (8) @(negedge clk);
        chk("wc_hold_busy", busy, 1);
        chk("wc_hold_nofetch", n_fetch - f0, 0);
        db_ready = 1'b1;
        @(negedge clk);
        chk("wc_release_fetch", tri_fetch, 1);
        wait_high(2, "raster_start_ign", 50);
        repeat (2) @(negedge clk);
        tri_count = 8'd5; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        frame_start = 1'b1; raster_done = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; raster_done = 1'b0;
        wait_high(3, "frame_done_ign", 50);
        repeat (20) @(negedge clk);
        chk("ign_no_extra_frame", busy, 0);
        chk("ign_clears", n_clear - c0, 1);
        chk("ign_dones", n_done - d0, 1);
        s0 = n_start;
        raster_done = 1'b1;
        @(negedge clk);
        raster_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_raster_done_busy", busy, 0);
        chk("idle_raster_done_starts", n_start - s0, 0);
        chk("idle_raster_done_drawn", tri_drawn, 1);

        // Reset during triangle 1 of 4 abandons the frame
        d0 = n_done;
        addr_q.push_back(8'd0); addr_q.push_back(8'd1);
        start_frame(4);
        serve_tri(3);
        wait_high(2, "raster_start_t1", 50);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_strobes", {busy, clear_req, tri_fetch, raster_start, frame_done, timeout_err}, 0);
        chk("midrst_addr", tri_addr, 0);
        chk("midrst_drawn", tri_drawn, 0);
        repeat (10) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);
        addr_q.push_back(8'd0); addr_q.push_back(8'd1);
        drawn_q.push_back(8'd2);
        start_frame(2);
        serve_tri(4);
        serve_tri(4);
        wait_high(3, "frame_done_post_rst", 50);
        @(negedge clk);
        chk("post_rst_dones", n_done - d0, 1);

        // Maximum count renders every triangle without wrapping
        s0 = n_start;
        for (int i = 0; i < 255; i++) addr_q.push_back(W'(i));
        drawn_q.push_back(8'd255);
        start_frame(255);
        for (int t = 0; t < 255; t++) serve_tri(1);
        wait_high(3, "frame_done_max", 50);
        @(negedge clk);
        chk("max_starts", n_start - s0, 255);
        chk("max_drawn", tri_drawn, 255);

`ifdef RENDER_SCHED_TIMEOUT_EN
        // Rasterizer never answers: watchdog advances both triangles
        s0 = n_start;
        addr_q.push_back(8'd0); addr_q.push_back(8'd1);
        drawn_q.push_back(8'd2);
        start_frame(2);
        wait_high(3, "frame_done_tmo", 200);
        @(negedge clk);
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_starts", n_start - s0, 2);
        drawn_q.push_back(8'd0);
        start_frame(0);
        chk("tmo_err_cleared", timeout_err, 0);
        wait_high(3, "frame_done_tmo_clr", 50);
`else
        // Slow rasterizer: without the watchdog the block simply waits
        addr_q.push_back(8'd0);
        drawn_q.push_back(8'd1);
        start_frame(1);
        serve_tri(40);
        wait_high(3, "frame_done_slow", 50);
        @(negedge clk);
        chk("slow_no_tmo", timeout_err, 0);
`endif

        repeat (3) @(negedge clk);
        chk("addr_q_empty", addr_q.size(), 0);
        chk("drawn_q_empty", drawn_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 Parameter TRI_ADDR_WIDTH, default 8: width of triangle index and count.
REQ-002 Parameter RASTER_TIMEOUT, default 65535: maximum cycles in WAIT_RASTER (used only with the timeout feature).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 frame_start  in  1  one-cycle request to render a frame.
REQ-006 tri_count  in  TRI_ADDR_WIDTH  triangles in the frame; sampled only on an accepted frame_start.
REQ-007 clear_req  out  1  one-cycle clear pulse to the framebuffer and depth buffer.
REQ-008 fb_ready  in  1  framebuffer clear complete/idle.
REQ-009 db_ready  in  1  depth buffer clear complete/idle.
REQ-010 tri_addr  out  TRI_ADDR_WIDTH  index of the current triangle in vertex memory.
REQ-011 tri_fetch  out  1  one-cycle read strobe; vertex data is valid on the following cycle.
REQ-012 raster_start  out  1  one-cycle start pulse to the rasterizer.
REQ-013 raster_done  in  1  rasterizer finished the current triangle.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_done  out  1  one-cycle pulse when the frame is complete.
REQ-016 tri_drawn  out  TRI_ADDR_WIDTH  triangles completed in the current frame.
REQ-017 timeout_err  out  1  sticky rasterizer-timeout flag.

Function
REQ-018 States SHALL be IDLE, CLEAR, WAIT_CLEAR, FETCH, LOAD, START, WAIT_RASTER, NEXT and DONE; all outputs SHALL be registered and decoded from the state.
REQ-019 IDLE: frame_start=1 at edge N latches tri_count, zeroes tri_addr and tri_drawn, and enters CLEAR; clear_req SHALL be high during cycle N+1 only.
REQ-020 CLEAR SHALL go to WAIT_CLEAR. WAIT_CLEAR SHALL ignore the ready inputs on its first cycle, then advance once fb_ready and db_ready are both high in the same cycle.
REQ-021 On leaving WAIT_CLEAR: latched count 0 -> DONE; otherwise -> FETCH.
REQ-022 Triangle path: FETCH (tri_fetch=1) -> LOAD (one wait cycle) -> START (raster_start=1) -> WAIT_RASTER. Each of these strobes SHALL be exactly one cycle long.
REQ-023 WAIT_RASTER SHALL exit to NEXT on raster_done=1. raster_done in any other state SHALL be ignored.
REQ-024 NEXT: tri_drawn+1. If tri_addr equals count-1 -> DONE; otherwise tri_addr+1 -> FETCH.
REQ-025 DONE: frame_done=1 for one cycle -> IDLE. tri_drawn SHALL hold its value until the next accepted frame_start.
REQ-026 frame_start while busy=1 SHALL be ignored; it is not queued.
REQ-027 Counters SHALL be unsigned. Count 2^TRI_ADDR_WIDTH-1 is the maximum and SHALL render all triangles without wrapping.
REQ-028 frame_start and raster_done both high in the same cycle while in WAIT_RASTER: only the raster_done SHALL be acted on.

Reset
REQ-029 rst=1 SHALL force IDLE on the next edge, from any state. It SHALL also clear clear_req, tri_fetch, raster_start, frame_done, busy, tri_addr, tri_drawn, timeout_err and the latched count.
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_done pulse. The first frame_start after rst deasserts SHALL be accepted.

Configuration
REQ-031 Macro RENDER_SCHED_TIMEOUT_EN defined: a cycle counter SHALL run in WAIT_RASTER.
- If it reaches RASTER_TIMEOUT without raster_done, the block sets timeout_err and goes to NEXT; tri_drawn still increments.
- timeout_err clears only on rst or an accepted frame_start.
REQ-032 Macro undefined: WAIT_RASTER SHALL wait indefinitely, timeout_err SHALL be tied 0, and no timeout counter is synthesized.

Verification
REQ-033 Reset, then frame_start with tri_count=3, fb_ready/db_ready asserted 5 cycles after clear_req, raster_done 10 cycles after each raster_start -> clear_req once, tri_addr sequence 0,1,2, three raster_start pulses, one frame_done, tri_drawn=3.
REQ-034 tri_count=0 -> clear_req once, no tri_fetch, no raster_start, frame_done two or more cycles after both readies are high, tri_drawn=0.
REQ-035 Both readies held high throughout -> WAIT_CLEAR lasts exactly 2 cycles. fb_ready high with db_ready low -> no advance until db_ready=1.
REQ-036 frame_start pulsed during WAIT_RASTER, and raster_done pulsed in IDLE -> both ignored, with no extra frame and no state change.
REQ-037 rst asserted during WAIT_RASTER of triangle 1 of 4 -> IDLE with all outputs 0 and no frame_done; a new frame_start with tri_count=2 then completes normally.
REQ-038 RENDER_SCHED_TIMEOUT_EN defined, RASTER_TIMEOUT=20, raster_done never asserted, tri_count=2 -> timeout_err=1, frame_done pulses, tri_drawn=2. The next frame_start clears timeout_err.
